subpel_output_drain: RTL
========================

# subpel_output_drain

Drains the three interpolated sub-pixel planes (A, B, C; 320 pixels × 8 bits each) out of the interpolation core. It snapshots all three 2560-bit planes on a capture pulse, then streams them as 64-bit words (8 pixels per word) over a valid/ready interface. It sits between the interpolation top-level's output fillers and the downstream frame-store writer, and is the consumer end of the `out_A`/`out_B`/`out_C` buffers.

## Interface
- `NUM_WORDS`, 40: 64-bit words per plane (2560/64).
- `WORD_W`, 64: output word width in bits; must equal `num_pixel*sizeofPixel`.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; asynchronous, active-high.
- `capture`  input  1  single-cycle pulse: the in_A/in_B/in_C planes are complete.
- `in_A`  input  2560  plane A pixels; pixel p occupies bits [8p +: 8].
- `in_B`  input  2560  plane B pixels.
- `in_C`  input  2560  plane C pixels.
- `out_ready`  input  1  downstream accepts the word.
- `out_valid`  output  1  `out_data` is valid.
- `out_data`  output  64  current word.
- `out_plane`  output  2  plane tag: 0=A, 1=B, 2=C.
- `out_index`  output  6  word index within the plane, 0..39.
- `out_last`  output  1  final word of the frame (plane C, index 39).
- `frame_done`  output  1  one-cycle pulse after the final handshake.
- `busy`  output  1  a frame is held or streaming.
- `overflow`  output  1  sticky flag: a capture was dropped.

## Operation
- Handshake: a word transfers on a rising edge with `out_valid && out_ready`.
- States:
  - IDLE: `capture` latches `in_A`, `in_B`, `in_C` into the active buffer and moves to SEND.
  - SEND: presents word `in_P[64*k +: 64]` for plane P = `out_plane` and k = `out_index`.
    - On each handshake, `out_index` increments.
    - At index 39, `out_index` wraps to 0 and `out_plane` advances A→B→C.
    - The handshake on C/39 ends the frame.
  - End of frame: `frame_done` pulses the next cycle and the block returns to IDLE.
- `out_data`, `out_plane`, `out_index` and `out_last` are held stable while `out_valid && !out_ready`.
- `out_valid` never drops without a handshake.
- `busy` = state != IDLE, or a pending frame is held.
- Capture while busy, without the double buffer: the capture is ignored, `overflow` is set, and the current stream is unaffected.
- A capture in the same cycle as the final handshake counts as busy (dropped, or queued when double-buffered).
- `overflow` is cleared only by `rst`.
- `rst` mid-frame: the stream is abandoned, buffers are invalidated, and the block returns to IDLE.
- Reset values: `out_valid`=0, `out_data`=0, `out_plane`=0, `out_index`=0, `out_last`=0, `frame_done`=0, `busy`=0, `overflow`=0.

## Timing
- Capture → `out_valid`: 1 cycle. `capture` is sampled at edge N; `out_valid` is high after edge N, presenting A/0.
- Throughput: 1 word per cycle with `out_ready` held high, so 120 cycles per frame.
- `frame_done` is high for exactly the one cycle following the C/39 handshake. `out_valid` is 0 in that cycle unless a pending frame exists.
- All outputs are registered; there is no combinational path from `out_ready` to any output.

## Configuration
- `SUBPEL_DRAIN_DOUBLE_BUF_EN` defined:
  - Adds a pending 3×2560-bit buffer. A capture while streaming fills it; the pending flag counts toward `busy`.
  - On the final handshake with pending valid, pending moves to active. Streaming continues with A/0 in the next cycle: `out_valid` stays high and `frame_done` still pulses.
  - `overflow` is set only when a capture arrives while pending is already full.
- Undefined: single buffer; any capture while busy sets `overflow`.

## Test plan
- Reset, then capture with `in_A[8p+:8]=p`, `in_B=p+64`, `in_C=p+128` (mod 256), `out_ready`=1. Expect:
  - First word A/0 = 0x0706050403020100.
  - `out_last` only on C/39.
  - `frame_done` exactly 121 cycles after capture.
- Random `out_ready` backpressure, 30% low → all 120 words arrive in order; data and tags are held stable while stalled.
- Second capture at word B/10 without the macro → `overflow`=1; frame 1 completes intact; `busy` falls after `frame_done`.
- With the macro, a second capture at B/10 → frame 2 A/0 follows C/39 with no idle cycle. A third capture before the swap sets `overflow`.
- Assert `rst` at word A/20 → all outputs return to reset values immediately. A fresh capture then restarts at A/0.

Source files
------------

// File: rtl/subpel_output_drain.sv
// subpel_output_drain: snapshots the A/B/C sub-pel planes on capture and streams them as 64-bit valid/ready words.
// Define SUBPEL_DRAIN_DOUBLE_BUF_EN to add a pending frame buffer so a capture during streaming is queued.
module subpel_output_drain #(
    parameter int NUM_WORDS = 40,
    parameter int WORD_W    = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        capture,
    input  logic [NUM_WORDS*WORD_W-1:0] in_A,
    input  logic [NUM_WORDS*WORD_W-1:0] in_B,
    input  logic [NUM_WORDS*WORD_W-1:0] in_C,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [WORD_W-1:0]           out_data,
    output logic [1:0]                  out_plane,
    output logic [5:0]                  out_index,
    output logic                        out_last,
    output logic                        frame_done,
    output logic                        busy,
    output logic                        overflow
);
    localparam int PW = NUM_WORDS * WORD_W;
    localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state;
    logic [PW-1:0] act_a, act_b, act_c, sel, src_a, src_b, src_c;
    logic hs, fin, load_act, pend_n, drop;
    logic [1:0] nplane;
    logic [5:0] nidx;
    logic [WORD_W-1:0] first_word;
    assign hs         = out_valid && out_ready;
    assign fin        = hs && out_last;
    assign nidx       = (out_index == LAST_IDX) ? 6'd0 : out_index + 6'd1;
    assign nplane     = (out_index == LAST_IDX) ? out_plane + 2'd1 : out_plane;
    assign sel        = (nplane == 2'd0) ? act_a : (nplane == 2'd1) ? act_b : act_c;
    assign first_word = src_a[WORD_W-1:0];
`ifdef SUBPEL_DRAIN_DOUBLE_BUF_EN
    logic [PW-1:0] pend_a, pend_b, pend_c;
    logic pend_v, fill_pend, load_pend;
    // A capture coinciding with the final handshake and no pending frame restarts directly from the inputs.
    assign load_pend = fin && pend_v;
    assign load_act  = load_pend || (capture && (state == IDLE || (fin && !pend_v)));
    assign fill_pend = capture && state == SEND && !fin && !pend_v;
    assign drop      = capture && state == SEND && pend_v;
    assign pend_n    = fill_pend || (pend_v && !load_pend);
    assign src_a     = load_pend ? pend_a : in_A;
    assign src_b     = load_pend ? pend_b : in_B;
    assign src_c     = load_pend ? pend_c : in_C;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_v <= 1'b0;
        else     pend_v <= pend_n;
    end
    always_ff @(posedge clk) begin
        if (fill_pend) begin
            pend_a <= in_A;
            pend_b <= in_B;
            pend_c <= in_C;
        end
    end
`else
    assign load_act = capture && state == IDLE;
    assign drop     = capture && state == SEND;
    assign pend_n   = 1'b0;
    assign src_a    = in_A;
    assign src_b    = in_B;
    assign src_c    = in_C;
`endif
    always_ff @(posedge clk) begin
        if (load_act) begin
            act_a <= src_a;
            act_b <= src_b;
            act_c <= src_c;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_plane  <= '0;
            out_index  <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= fin;
            busy       <= (state == SEND && !fin) || load_act || pend_n;
            if (drop) overflow <= 1'b1;
            if (load_act) begin
                state     <= SEND;
                out_valid <= 1'b1;
                out_data  <= first_word;
                out_plane <= 2'd0;
                out_index <= 6'd0;
                out_last  <= 1'b0;
            end else if (fin) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_plane <= 2'd0;
                out_index <= 6'd0;
                out_last  <= 1'b0;
            end else if (hs) begin
                out_data  <= sel[WORD_W*nidx +: WORD_W];
                out_plane <= nplane;
                out_index <= nidx;
                out_last  <= nplane == 2'd2 && nidx == LAST_IDX;
            end
        end
    end
endmodule
